fetch_decode_ctrl: RTL
======================

# fetch_decode_ctrl

Instruction-fetch control and decode-register stage that sits directly downstream of the program memory. Each cycle it consumes the fetched instruction `ins` and its address `current_address` and registers them into the decode stage. It drives the program memory's PC-control inputs back: `jmp_loc`, `pc_mux_sel`, `stall` and `stall_pm`. It resolves jumps, inserts load-use bubbles, flushes the wrong-path slot and implements halt.

## Interface
- `NOP`, 32'h0000_0000, bubble value written into `dec_ins`
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `ins`  in  32  instruction from program memory for `current_address`, same cycle
- `current_address`  in  16  PC value of `ins`
- `zero_flag`  in  1  ALU zero flag, valid every cycle
- `hold`  in  1  external freeze, e.g. data-memory busy
- `jmp_loc`  out  16  jump target to program memory; registered
- `pc_mux_sel`  out  1  1 = PC loads `jmp_loc`; registered
- `stall`  out  1  1 = PC holds; combinational
- `stall_pm`  out  1  1 = program-memory output holds; combinational
- `dec_ins`  out  32  decode-stage instruction; registered
- `dec_address`  out  16  decode-stage PC; registered
- `dec_valid`  out  1  `dec_ins` is a real instruction; registered
- `halted`  out  1  HALT state indicator

## Operation
- Instruction fields:
  - `op` = ins[31:27]
  - `rd` = ins[25:22]
  - `rs1` = ins[21:18]
  - `rs2` = ins[17:14]
  - `imm` = ins[15:0]
- Opcodes:
  - JMP = 5'b11000: unconditional jump.
  - JZ = 5'b11001: taken if `zero_flag` = 1.
  - JNZ = 5'b11010: taken if `zero_flag` = 0.
  - LOAD = 5'b10100.
  - HLT = 5'b11111.
  - All other opcodes pass through without control effect.
- Internal state:
  - `ld_pend`: set when the registered `dec_ins` is a valid LOAD.
  - `ld_rd`: the `rd` of that LOAD.
- FSM states are RUN, FLUSH and HALT. The reset state is RUN.
- Hazard condition: `haz` = RUN & `ld_pend` & (`rs1` == `ld_rd` | `rs2` == `ld_rd`). Register fields are compared for every opcode.
- `stall` = `stall_pm` = `hold` | `haz` | (state == HALT).
- Priority, highest first: `hold`, HALT, FLUSH, `haz`, jump/HLT decode, normal issue.
- `hold` = 1: every register keeps its value, including the FSM state, `pc_mux_sel`, `jmp_loc` and the decode outputs.
- RUN, `haz`: load a bubble (`dec_ins` = NOP, `dec_valid` = 0); clear `ld_pend`; stay in RUN. The jump/HLT in `ins` is re-evaluated next cycle.
- RUN, taken jump:
  - Load `dec_ins`/`dec_address` from `ins`/`current_address`; `dec_valid` = 1.
  - Set `jmp_loc` = `imm` and `pc_mux_sel` = 1.
  - Go to FLUSH.
- RUN, not-taken JZ/JNZ: issue normally; stay in RUN.
- RUN, HLT: issue HLT into decode; go to HALT.
- RUN, other opcodes: issue normally.
- FLUSH:
  - `ins` is the wrong-path instruction at jump address + 1. Discard it: bubble into decode, no decode of its opcode.
  - Clear `pc_mux_sel`; go to RUN.
  - A target equal to address + 1 is still flushed.
- HALT:
  - Bubble into decode, `stall` = `stall_pm` = 1, `halted` = 1.
  - Exit only via `reset`.
- Reset values: `jmp_loc` = 0, `pc_mux_sel` = 0, `dec_ins` = NOP, `dec_address` = 0, `dec_valid` = 0, `ld_pend` = 0, `halted` = 0, state = RUN. `stall` and `stall_pm` are 0 unless `hold` = 1.
- Reset mid-FLUSH or mid-HALT: the block immediately returns to its reset values, with no pending jump.

## Timing
- Decode latency is 1 cycle: `ins` sampled at edge k appears on `dec_ins` after edge k.
- Taken jump seen in cycle N:
  - `pc_mux_sel` = 1 during N+1.
  - PC loads the target at the end of N+1.
  - `current_address` = target in N+2.
  - Penalty: 1 bubble.
- Load-use: 1 bubble. `stall` is high in the same cycle the dependent instruction is on `ins`.
- `hold` asserted in FLUSH: `pc_mux_sel` stays 1 and the state stays FLUSH until `hold` drops.
- `stall` and `stall_pm` are always equal.

## Test plan
- Reset low for 2 cycles, then high with `ins` = NOP → all registered outputs 0, `stall` = 0, PC free-running.
- `ins` = JMP, `imm` = 16'h0008, at address 3 → `pc_mux_sel` = 1 and `jmp_loc` = 16'h0008 in the next cycle; the next `dec_valid` = 0; `current_address` = 8 two cycles after the JMP.
- LOAD with `rd` = 4, followed by an ADD with `rs1` = 4 → `stall` = `stall_pm` = 1 for exactly 1 cycle, one bubble, then the ADD issues; an ADD with `rs1` = 5 gives no stall.
- JZ with `zero_flag` = 0 → no redirect, no bubble; with `zero_flag` = 1 → redirect plus 1 bubble. A JZ that also has a load-use dependency → stall first, then the jump.
- `hold` = 1 for 3 cycles during FLUSH → outputs frozen, `pc_mux_sel` held at 1; after release, the jump completes normally.
- HLT → `halted` = 1, `stall` stuck at 1 for 10 cycles; reset pulsed low mid-halt → immediate return to reset values.

Source files
------------

// File: rtl/fetch_decode_ctrl_if.sv
// Bundle between the fetch/decode control block and the program memory / decode stage.
// The master modport is the control block; the slave modport is the program-memory side.
interface fetch_decode_ctrl_if;
  logic [31:0] ins;
  logic [15:0] current_address;
  logic        zero_flag;
  logic        hold;
  logic [15:0] jmp_loc;
  logic        pc_mux_sel;
  logic        stall;
  logic        stall_pm;
  logic [31:0] dec_ins;
  logic [15:0] dec_address;
  logic        dec_valid;
  logic        halted;

  modport master (
    input  ins, current_address, zero_flag, hold,
    output jmp_loc, pc_mux_sel, stall, stall_pm,
    output dec_ins, dec_address, dec_valid, halted
  );

  modport slave (
    output ins, current_address, zero_flag, hold,
    input  jmp_loc, pc_mux_sel, stall, stall_pm,
    input  dec_ins, dec_address, dec_valid, halted
  );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Fetch control and decode register: resolves jumps, inserts load-use bubbles,
// flushes the wrong-path slot after a taken jump and implements halt.
module fetch_decode_ctrl (
  input  logic                clk,
  input  logic                reset,
  fetch_decode_ctrl_if.master bus
);
  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [4:0]  OP_JMP  = 5'b11000;
  localparam logic [4:0]  OP_JZ   = 5'b11001;
  localparam logic [4:0]  OP_JNZ  = 5'b11010;
  localparam logic [4:0]  OP_LOAD = 5'b10100;
  localparam logic [4:0]  OP_HLT  = 5'b11111;

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  state_t      state_reg, state_next;
  logic [15:0] jmp_loc_reg, jmp_loc_next;
  logic        pc_mux_sel_reg, pc_mux_sel_next;
  logic [31:0] dec_ins_reg, dec_ins_next;
  logic [15:0] dec_address_reg, dec_address_next;
  logic        dec_valid_reg, dec_valid_next;
  logic        ld_pend_reg, ld_pend_next;
  logic [3:0]  ld_rd_reg, ld_rd_next;

  logic [4:0]  op;
  logic [3:0]  rd, rs1, rs2;
  logic [15:0] imm;
  logic        haz;
  logic        jump_taken;

  assign op  = bus.ins[31:27];
  assign rd  = bus.ins[25:22];
  assign rs1 = bus.ins[21:18];
  assign rs2 = bus.ins[17:14];
  assign imm = bus.ins[15:0];

  // Register fields are compared regardless of opcode, so a dependent jump also waits.
  assign haz = (state_reg == RUN) && ld_pend_reg && ((rs1 == ld_rd_reg) || (rs2 == ld_rd_reg));

  always_comb begin
    jump_taken = 1'b0;
    case (op)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = bus.zero_flag;
      OP_JNZ:  jump_taken = ~bus.zero_flag;
      default: jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    jmp_loc_next     = jmp_loc_reg;
    pc_mux_sel_next  = pc_mux_sel_reg;
    dec_ins_next     = dec_ins_reg;
    dec_address_next = dec_address_reg;
    dec_valid_next   = dec_valid_reg;
    ld_pend_next     = ld_pend_reg;
    ld_rd_next       = ld_rd_reg;
    if (!bus.hold) begin
      case (state_reg)
        HALT: begin
          dec_ins_next   = NOP;
          dec_valid_next = 1'b0;
          ld_pend_next   = 1'b0;
        end
        FLUSH: begin
          // The slot after a taken jump is always wrong-path, even if the target is address + 1.
          dec_ins_next    = NOP;
          dec_valid_next  = 1'b0;
          ld_pend_next    = 1'b0;
          pc_mux_sel_next = 1'b0;
          state_next      = RUN;
        end
        default: begin
          if (haz) begin
            dec_ins_next   = NOP;
            dec_valid_next = 1'b0;
            ld_pend_next   = 1'b0;
          end else begin
            dec_ins_next     = bus.ins;
            dec_address_next = bus.current_address;
            dec_valid_next   = 1'b1;
            ld_pend_next     = (op == OP_LOAD);
            ld_rd_next       = rd;
            if (jump_taken) begin
              jmp_loc_next    = imm;
              pc_mux_sel_next = 1'b1;
              state_next      = FLUSH;
            end else if (op == OP_HLT) begin
              state_next = HALT;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= RUN;
      jmp_loc_reg     <= 16'h0000;
      pc_mux_sel_reg  <= 1'b0;
      dec_ins_reg     <= NOP;
      dec_address_reg <= 16'h0000;
      dec_valid_reg   <= 1'b0;
      ld_pend_reg     <= 1'b0;
      ld_rd_reg       <= 4'h0;
    end else begin
      state_reg       <= state_next;
      jmp_loc_reg     <= jmp_loc_next;
      pc_mux_sel_reg  <= pc_mux_sel_next;
      dec_ins_reg     <= dec_ins_next;
      dec_address_reg <= dec_address_next;
      dec_valid_reg   <= dec_valid_next;
      ld_pend_reg     <= ld_pend_next;
      ld_rd_reg       <= ld_rd_next;
    end
  end

  assign bus.stall       = bus.hold | haz | (state_reg == HALT);
  assign bus.stall_pm    = bus.stall;
  assign bus.halted      = (state_reg == HALT);
  assign bus.jmp_loc     = jmp_loc_reg;
  assign bus.pc_mux_sel  = pc_mux_sel_reg;
  assign bus.dec_ins     = dec_ins_reg;
  assign bus.dec_address = dec_address_reg;
  assign bus.dec_valid   = dec_valid_reg;
endmodule
